// File: rtl/kiwi_run_seq_pkg.sv
// kiwi_run_seq_pkg: state encoding and status codes shared by the run sequencer
package kiwi_run_seq_pkg;
   typedef enum logic [1:0] {IDLE, HOLD_RST, RUN, REPORT} state_t;
   localparam logic [1:0] ST_NONE    = 2'd0;
   localparam logic [1:0] ST_OK      = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_STALE   = 2'd3;
endpackage

// File: rtl/kiwi_sat_counter.sv
// kiwi_sat_counter: saturating up-counter with clear taking priority over increment
module kiwi_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q;
   // count up, stick at all-ones, clear wins
   always_ff @(posedge clk or posedge reset)
      if (reset) q_q <= '0;
      else if (clr) q_q <= '0;
      else if (inc && q_q != '1) q_q <= q_q + 1'b1;
   assign q = q_q;
endmodule

// File: rtl/kiwi_run_sequencer.sv
// kiwi_run_sequencer: drives reset/run/report cycles of one Kiwi DUT; KIWI_RUN_SEQ_TRACE_EN enables run trace printing
module kiwi_run_sequencer
   import kiwi_run_seq_pkg::*;
#(
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1800,
   parameter int CNT_W          = 32,
   parameter int RUNS_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dut_done,
   output logic              dut_reset,
   output logic              busy,
   output logic              fin_pulse,
   output logic [1:0]        status,
   output logic [CNT_W-1:0]  cycles,
   output logic [RUNS_W-1:0] run_count
);
   localparam int HW = $clog2(RESET_CYCLES + 1);
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q;
   logic          first_q, dut_reset_q, busy_q, fin_q;
   logic [1:0]    status_q, status_d;
   logic          timeout_hit, end_run, cyc_clr, cyc_inc;
   // next-state and run-termination decisions
   always_comb begin
      timeout_hit = TIMEOUT_CYCLES != 0 && ({1'b0, cycles} + 1'b1) == (CNT_W + 1)'(TIMEOUT_CYCLES);
      end_run     = state_q == RUN && (dut_done || timeout_hit);
      cyc_clr     = state_q == IDLE && start;
      cyc_inc     = state_q == RUN && !dut_done;
      status_d    = (first_q && dut_done) ? ST_STALE : dut_done ? ST_OK : ST_TIMEOUT;
      state_d     = state_q == IDLE     ? (start ? HOLD_RST : IDLE) :
                    state_q == HOLD_RST ? (hold_q == HW'(1) ? RUN : HOLD_RST) :
                    state_q == RUN      ? (end_run ? REPORT : RUN) : IDLE;
   end
   // sequencer state with all outputs registered from the next state
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         first_q     <= 1'b0;
         dut_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         fin_q       <= 1'b0;
         status_q    <= ST_NONE;
      end else begin
         state_q     <= state_d;
         hold_q      <= state_q == HOLD_RST ? hold_q - 1'b1 : HW'(RESET_CYCLES);
         first_q     <= state_d == RUN && state_q != RUN;
         dut_reset_q <= state_d != RUN;
         busy_q      <= state_d != IDLE;
         fin_q       <= state_d == REPORT;
         if (cyc_clr) status_q <= ST_NONE;
         else if (end_run) status_q <= status_d;
      end
   kiwi_sat_counter #(.W(CNT_W)) u_cycles (
      .clk(clk), .reset(reset), .clr(cyc_clr), .inc(cyc_inc), .q(cycles)
   );
   kiwi_sat_counter #(.W(RUNS_W)) u_runs (
      .clk(clk), .reset(reset), .clr(1'b0), .inc(end_run), .q(run_count)
   );
   assign dut_reset = dut_reset_q;
   assign busy      = busy_q;
   assign fin_pulse = fin_q;
   assign status    = status_q;
`ifdef KIWI_RUN_SEQ_TRACE_EN
   // simulation-only run trace
   always @(posedge clk) begin
      if (!reset && state_q == REPORT) $display("run %0d status %0d cycles %0d", run_count, status_q, cycles);
      if (!reset && end_run && !dut_done) $display("kiwi_run_sequencer: timeout");
   end
`else
`endif
endmodule

// File: tb/tb_kiwi_run_sequencer.sv
// tb_kiwi_run_sequencer: scoreboard bench for the run sequencer with behavioural done-flag DUT models
module tb_kiwi_run_sequencer;
   typedef struct {
      logic [1:0] st;
      int         cyc;
      int         rc;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_a = 1'b1, rst_b = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        tie_a = 1'b0;
   int          lat_a = 1, lat_b = 1;
   int          cnt_a = 0, cnt_b = 0;
   logic        done_a = 1'b0, done_b = 1'b0;
   logic        dut_done_a, dut_done_b;
   logic        dut_reset_a, dut_reset_b, busy_a, busy_b, fin_a, fin_b;
   logic [1:0]  status_a, status_b;
   logic [31:0] cycles_a, cycles_b;
   logic [1:0]  run_count_a;
   logic [15:0] run_count_b;
   int          checks = 0, failures = 0;
   exp_t        q_a[$], q_b[$];
   exp_t        ea, eb;
   always #5 clk = ~clk;
   kiwi_run_sequencer #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(32), .RUNS_W(2)) u_a (
      .clk(clk), .reset(rst_a), .start(start_a), .dut_done(dut_done_a), .dut_reset(dut_reset_a),
      .busy(busy_a), .fin_pulse(fin_a), .status(status_a), .cycles(cycles_a), .run_count(run_count_a)
   );
   kiwi_run_sequencer #(.RESET_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(32), .RUNS_W(16)) u_b (
      .clk(clk), .reset(rst_b), .start(start_b), .dut_done(dut_done_b), .dut_reset(dut_reset_b),
      .busy(busy_b), .fin_pulse(fin_b), .status(status_b), .cycles(cycles_b), .run_count(run_count_b)
   );
   // model DUTs: sticky done raised lat cycles after reset release
   always @(posedge clk) begin
      if (dut_reset_a) begin
         cnt_a <= 0;
         done_a <= 1'b0;
      end else begin
         cnt_a <= cnt_a + 1;
         if (cnt_a + 1 >= lat_a) done_a <= 1'b1;
      end
      if (dut_reset_b) begin
         cnt_b <= 0;
         done_b <= 1'b0;
      end else begin
         cnt_b <= cnt_b + 1;
         if (cnt_b + 1 >= lat_b) done_b <= 1'b1;
      end
   end
   assign dut_done_a = tie_a | done_a;
   assign dut_done_b = done_b;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask
   // monitors: every fin_pulse must match the oldest expected report
   always @(negedge clk) begin
      if (fin_a) begin
         if (q_a.size() == 0) chk("a_unexpected_fin", 1, 0);
         else begin
            ea = q_a.pop_front();
            chk("a_status", status_a, ea.st);
            chk("a_cycles", cycles_a, ea.cyc);
            chk("a_run_count", run_count_a, ea.rc);
            chk("a_dut_reset_in_report", dut_reset_a, 1);
            chk("a_busy_in_report", busy_a, 1);
         end
      end
      if (fin_b) begin
         if (q_b.size() == 0) chk("b_unexpected_fin", 1, 0);
         else begin
            eb = q_b.pop_front();
            chk("b_status", status_b, eb.st);
            chk("b_cycles", cycles_b, eb.cyc);
            chk("b_run_count", run_count_b, eb.rc);
            chk("b_dut_reset_in_report", dut_reset_b, 1);
         end
      end
   end
   task automatic start_run(input bit b, input int r);
      if (b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      if (b) start_b = 1'b0; else start_a = 1'b0;
      chk("hold_busy", b ? busy_b : busy_a, 1);
      chk("hold_dut_reset", b ? dut_reset_b : dut_reset_a, 1);
      repeat (r - 1) begin
         @(negedge clk);
         chk("hold_dut_reset", b ? dut_reset_b : dut_reset_a, 1);
      end
      @(negedge clk);
      chk("run_dut_reset_low", b ? dut_reset_b : dut_reset_a, 0);
      chk("run_cycles_start", b ? cycles_b : cycles_a, 0);
   endtask
   task automatic drain(input bit b, input int budget);
      int n = 0;
      while ((b ? q_b.size() : q_a.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(b ? "b_drain" : "a_drain", b ? q_b.size() : q_a.size(), 0);
      @(negedge clk);
   endtask
   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("a_rst_dut_reset", dut_reset_a, 1);
      chk("a_rst_busy", busy_a, 0);
      chk("a_rst_fin", fin_a, 0);
      chk("a_rst_status", status_a, 0);
      chk("a_rst_cycles", cycles_a, 0);
      chk("a_rst_run_count", run_count_a, 0);
      chk("b_rst_dut_reset", dut_reset_b, 1);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("a_idle_dut_reset", dut_reset_a, 1);
      // done one cycle after release: OK with cycles=1
      lat_a = 1;
      q_a.push_back('{2'd1, 1, 1});
      start_run(0, 4);
      drain(0, 40);
      chk("a_status_held", status_a, 1);
      chk("a_cycles_held", cycles_a, 1);
      chk("a_idle_dut_reset_after", dut_reset_a, 1);
      // silent DUT: timeout at 20
      lat_a = 1000000;
      q_a.push_back('{2'd2, 20, 2});
      start_run(0, 4);
      drain(0, 60);
      chk("a_timeout_dut_reset", dut_reset_a, 1);
      chk("a_timeout_busy", busy_a, 0);
      // done tied high: stale
      tie_a = 1'b1;
      q_a.push_back('{2'd3, 0, 3});
      start_run(0, 4);
      drain(0, 40);
      tie_a = 1'b0;
      // clear run_count, then five back-to-back runs with start held
      rst_a = 1'b1;
      #1;
      chk("a_rerst_run_count", run_count_a, 0);
      chk("a_rerst_status", status_a, 0);
      @(negedge clk);
      rst_a = 1'b0;
      lat_a = 10;
      q_a.push_back('{2'd1, 10, 1});
      q_a.push_back('{2'd1, 10, 2});
      q_a.push_back('{2'd1, 10, 3});
      q_a.push_back('{2'd1, 10, 3});
      q_a.push_back('{2'd1, 10, 3});
      start_a = 1'b1;
      n = 0;
      while (q_a.size() > 1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("a_held_runs_progress", q_a.size() <= 1, 1);
      repeat (2) @(negedge clk);
      start_a = 1'b0;
      drain(0, 60);
      repeat (3) @(negedge clk);
      chk("a_no_extra_run", busy_a, 0);
      chk("a_sat_run_count", run_count_a, 3);
      // instance B: 2-cycle hold, OK after 7
      lat_b = 7;
      q_b.push_back('{2'd1, 7, 1});
      start_run(1, 2);
      drain(1, 40);
      chk("b_run_count", run_count_b, 1);
      // abort with reset at RUN cycle 50; mid-run start pulse ignored
      lat_b = 100;
      start_run(1, 2);
      repeat (20) @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      repeat (28) @(negedge clk);
      chk("b_cycles_at_50", cycles_b, 49);
      rst_b = 1'b1;
      #1;
      chk("b_abort_dut_reset", dut_reset_b, 1);
      chk("b_abort_status", status_b, 0);
      chk("b_abort_run_count", run_count_b, 0);
      chk("b_abort_busy", busy_b, 0);
      chk("b_abort_fin", fin_b, 0);
      @(negedge clk);
      rst_b = 1'b0;
      repeat (120) @(negedge clk);
      chk("b_after_abort_run_count", run_count_b, 0);
      chk("b_after_abort_busy", busy_b, 0);
      // timeout disabled: silent DUT keeps running
      lat_b = 1000000;
      start_run(1, 2);
      repeat (5000) @(negedge clk);
      chk("b_no_timeout_busy", busy_b, 1);
      chk("b_no_timeout_cycles", cycles_b, 5000);
      chk("b_no_timeout_status", status_b, 0);
      rst_b = 1'b1;
      @(negedge clk);
      chk("a_queue_empty", q_a.size(), 0);
      chk("b_queue_empty", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
